// File: rtl/a429_rx_decoder_pkg.sv
// Shared types and timing helpers for the ARINC-429 receive word decoder.
package a429_rx_decoder_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned CNT_W  = 6;

  // Line symbol, encoded as {hi, lo}
  typedef enum logic [1:0] {
    SYM_NULL = 2'b00,
    SYM_ZERO = 2'b01,
    SYM_ONE  = 2'b10,
    SYM_ILL  = 2'b11
  } sym_e;

  typedef enum logic [2:0] {
    ST_SYNC,
    ST_IDLE,
    ST_PULSE,
    ST_GAP,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic [WORD_W-1:0] dat;
    logic              par_err;
  } word_t;

  function automatic int unsigned bt_hs(input int unsigned clock_khz);
    return clock_khz / 100;
  endfunction

  function automatic int unsigned bt_ls(input int unsigned clock_khz);
    return (clock_khz * 8) / 100;
  endfunction

  function automatic int unsigned calc_cw(input int unsigned max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/a429_rx_sym.sv
// Registers the filtered HI/LO pair into a line symbol plus a symbol-change flag.
module a429_rx_sym
  import a429_rx_decoder_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic hi_i,
  input  logic lo_i,
  output sym_e sym,
  output logic chg
);

  sym_e sym_c;

  assign sym_c = sym_e'({hi_i, lo_i});

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      sym <= SYM_NULL;
      chg <= 1'b0;
    end else begin
      sym <= sym_c;
      chg <= (sym_c != sym);
    end
  end

endmodule

// File: rtl/a429_rx_decoder.sv
// ARINC-429 receive decoder: times RZ pulses/gaps, assembles 32-bit words, checks odd parity.
module a429_rx_decoder
  import a429_rx_decoder_pkg::*;
#(
  parameter int unsigned CLOCK_KHZ = 100 * 1000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              spd_i,
  input  logic              hi_i,
  input  logic              lo_i,
  output logic [WORD_W-1:0] dat_o,
  output logic              vld_o,
  output logic              par_err_o,
  output logic              err_o
);

  localparam int unsigned BT_HS = bt_hs(CLOCK_KHZ);
  localparam int unsigned BT_LS = bt_ls(CLOCK_KHZ);
  localparam int unsigned TMR_W = calc_cw(2 * BT_LS);

  localparam logic [TMR_W-1:0] BT_HS_T  = TMR_W'(BT_HS);
  localparam logic [TMR_W-1:0] BT_LS_T  = TMR_W'(BT_LS);
  localparam logic [TMR_W-1:0] GAP_HS_T = TMR_W'(2 * BT_HS - 1);
  localparam logic [TMR_W-1:0] GAP_LS_T = TMR_W'(2 * BT_LS - 1);

  sym_e              sym;
  logic              sym_chg;
  state_e            state_q, state_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WORD_W-1:0] sh_q, sh_d;
  word_t             out_q, out_d;
  logic              vld_d, err_d;
  logic              spd_q;
  logic [TMR_W-1:0]  bt_lim_c, gap_lim_c;
  logic              bit_c;

  a429_rx_sym u_sym (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .hi_i  (hi_i),
    .lo_i  (lo_i),
    .sym   (sym),
    .chg   (sym_chg)
  );

  assign bt_lim_c  = spd_q ? BT_HS_T : BT_LS_T;
  assign gap_lim_c = spd_q ? GAP_HS_T : GAP_LS_T;
  assign bit_c     = (sym == SYM_ONE);

  assign dat_o     = out_q.dat;
  assign par_err_o = out_q.par_err;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= ST_SYNC;
      tmr_q   <= '0;
      cnt_q   <= '0;
      sh_q    <= '0;
      out_q   <= '0;
      vld_o   <= 1'b0;
      err_o   <= 1'b0;
      spd_q   <= spd_i;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      out_q   <= out_d;
      vld_o   <= vld_d;
      err_o   <= err_d;
      spd_q   <= spd_i;
    end
  end

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    out_d   = out_q;
    vld_d   = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      ST_SYNC: begin
        cnt_d = '0;
        if (sym != SYM_NULL) begin
          tmr_d = '0;
        end else if (tmr_q >= gap_lim_c) begin
          tmr_d   = '0;
          state_d = ST_IDLE;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end

      ST_IDLE: begin
        if (sym == SYM_ILL) begin
          err_d   = 1'b1;
          tmr_d   = '0;
          state_d = ST_SYNC;
        end else if (sym != SYM_NULL) begin
          sh_d    = '0;
          sh_d[0] = bit_c;
          cnt_d   = CNT_W'(1);
          tmr_d   = '0;
          state_d = ST_PULSE;
        end
      end

      ST_PULSE: begin
        if (sym == SYM_NULL) begin
          tmr_d = '0;
          if (cnt_q == CNT_W'(WORD_W)) begin
            state_d       = ST_DONE;
            vld_d         = 1'b1;
            out_d.dat     = sh_q;
            out_d.par_err = ~^sh_q;
          end else begin
            state_d = ST_GAP;
          end
        end else if (sym_chg || (tmr_q >= bt_lim_c)) begin
          // opposite symbol, illegal symbol or a stuck line
          err_d   = 1'b1;
          tmr_d   = '0;
          state_d = ST_SYNC;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end

      ST_GAP: begin
        if (sym == SYM_NULL) begin
          if (tmr_q >= gap_lim_c) begin
            err_d   = 1'b1;
            tmr_d   = '0;
            state_d = ST_IDLE;
          end else begin
            tmr_d = tmr_q + TMR_W'(1);
          end
        end else if (sym == SYM_ILL) begin
          err_d   = 1'b1;
          tmr_d   = '0;
          state_d = ST_SYNC;
        end else begin
          sh_d[cnt_q[4:0]] = bit_c;
          cnt_d            = cnt_q + CNT_W'(1);
          tmr_d            = '0;
          state_d          = ST_PULSE;
        end
      end

      ST_DONE: begin
        tmr_d   = '0;
        state_d = ST_IDLE;
      end

      default: begin
        tmr_d   = '0;
        state_d = ST_SYNC;
      end
    endcase

    // A speed change drops any partial word without an error strobe
    if (spd_i != spd_q) begin
      state_d = ST_SYNC;
      tmr_d   = '0;
      cnt_d   = '0;
      out_d   = out_q;
      vld_d   = 1'b0;
      err_d   = 1'b0;
    end
  end

endmodule

// File: tb/tb_a429_rx_decoder.sv
// Randomized self-checking bench for a429_rx_decoder at 100 MHz, high speed (BT = 1000 clocks).
module tb_a429_rx_decoder;

  localparam int unsigned CLOCK_KHZ = 100000;
  localparam int          BT        = 1000;
  localparam int          PIPE      = 2;  // input register + decoder register

  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic        spd_i = 1'b1;
  logic        hi_i = 1'b0;
  logic        lo_i = 1'b0;
  logic [31:0] dat_o;
  logic        vld_o;
  logic        par_err_o;
  logic        err_o;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int both_cnt = 0;

  logic [31:0] vdat_q[$];
  logic        vpar_q[$];
  int          vcyc_q[$];
  int          ecyc_q[$];

  a429_rx_decoder #(.CLOCK_KHZ(CLOCK_KHZ)) dut (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .spd_i     (spd_i),
    .hi_i      (hi_i),
    .lo_i      (lo_i),
    .dat_o     (dat_o),
    .vld_o     (vld_o),
    .par_err_o (par_err_o),
    .err_o     (err_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every output strobe with the cycle it was seen in
  always @(negedge clk) begin
    if (vld_o === 1'b1) begin
      vdat_q.push_back(dat_o);
      vpar_q.push_back(par_err_o);
      vcyc_q.push_back(cyc);
    end
    if (err_o === 1'b1) ecyc_q.push_back(cyc);
    if ((vld_o === 1'b1) && (err_o === 1'b1)) both_cnt++;
  end

  // Reference: the 32 received bits must contain an odd number of ones
  function automatic logic exp_par_err(input logic [31:0] w);
    return (($countones(w) % 2) == 0);
  endfunction

  task automatic put(input logic h, input logic l, input int n);
    hi_i = h;
    lo_i = l;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Sends bits 0..n-1 of w, leaves the line NULL, returns the cycle the final NULL began
  task automatic send_bits(input logic [31:0] w, input int n, input int pmin, input int pmax,
                           input int gmin, input int gmax, output int t_end);
    for (int i = 0; i < n; i++) begin
      put(w[i], ~w[i], int'($urandom_range(pmax, pmin)));
      if (i < n - 1) put(1'b0, 1'b0, int'($urandom_range(gmax, gmin)));
    end
    hi_i  = 1'b0;
    lo_i  = 1'b0;
    t_end = cyc;
  endtask

  task automatic clear_q();
    vdat_q.delete();
    vpar_q.delete();
    vcyc_q.delete();
    ecyc_q.delete();
  endtask

  task automatic test_reset();
    rst_i = 1'b0;
    repeat (4) begin
      hi_i = 1'($urandom);
      lo_i = 1'($urandom);
      @(posedge clk);
    end
    #1;
    checks++; if (dat_o !== 32'h0) begin failures++; $display("FAIL reset_dat got=%h exp=0", dat_o); end
    checks++; if (vld_o !== 1'b0) begin failures++; $display("FAIL reset_vld got=%b exp=0", vld_o); end
    checks++; if (par_err_o !== 1'b0) begin failures++; $display("FAIL reset_par got=%b exp=0", par_err_o); end
    checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err_o); end
  endtask

  task automatic test_powerup();
    logic [31:0] w;
    int t;
    clear_q();
    rst_i = 1'b1;
    send_bits($urandom, 32, 1, 20, 1, 20, t);
    put(1'b0, 1'b0, 2*BT + 10);
    checks++; if (vdat_q.size() != 0) begin failures++; $display("FAIL powerup_partial_vld got=%0d exp=0", vdat_q.size()); end
    checks++; if (ecyc_q.size() != 0) begin failures++; $display("FAIL powerup_partial_err got=%0d exp=0", ecyc_q.size()); end
    clear_q();
    w = $urandom;
    send_bits(w, 32, 1, 20, 1, 20, t);
    put(1'b0, 1'b0, 10);
    checks++;
    if (vdat_q.size() != 1) begin
      failures++; $display("FAIL powerup_vld_count got=%0d exp=1", vdat_q.size());
    end else begin
      checks++; if (vdat_q[0] !== w) begin failures++; $display("FAIL powerup_dat got=%h exp=%h", vdat_q[0], w); end
      checks++; if (vpar_q[0] !== exp_par_err(w)) begin failures++; $display("FAIL powerup_par got=%b exp=%b", vpar_q[0], exp_par_err(w)); end
    end
  endtask

  task automatic test_basic();
    int t;
    clear_q();
    put(1'b0, 1'b0, 2*BT);
    send_bits(32'h0000_0001, 32, 500, 500, 500, 500, t);
    put(1'b0, 1'b0, 10);
    checks++;
    if (vdat_q.size() != 1) begin
      failures++; $display("FAIL basic_vld_count got=%0d exp=1", vdat_q.size());
    end else begin
      checks++; if (vdat_q[0] !== 32'h1) begin failures++; $display("FAIL basic_dat got=%h exp=00000001", vdat_q[0]); end
      checks++; if (vpar_q[0] !== 1'b0) begin failures++; $display("FAIL basic_par got=%b exp=0", vpar_q[0]); end
      checks++; if (vcyc_q[0] != t + PIPE) begin failures++; $display("FAIL basic_latency got=%0d exp=%0d", vcyc_q[0], t + PIPE); end
    end
    checks++; if (ecyc_q.size() != 0) begin failures++; $display("FAIL basic_err got=%0d exp=0", ecyc_q.size()); end
    checks++; if (dat_o !== 32'h1) begin failures++; $display("FAIL basic_hold got=%h exp=00000001", dat_o); end
  endtask

  task automatic test_parity();
    int t;
    clear_q();
    send_bits(32'h0000_0003, 32, 1, 20, 1, 20, t);
    put(1'b0, 1'b0, 10);
    checks++;
    if (vdat_q.size() != 1) begin
      failures++; $display("FAIL parity_vld_count got=%0d exp=1", vdat_q.size());
    end else begin
      checks++; if (vdat_q[0] !== 32'h3) begin failures++; $display("FAIL parity_dat got=%h exp=00000003", vdat_q[0]); end
      checks++; if (vpar_q[0] !== 1'b1) begin failures++; $display("FAIL parity_par got=%b exp=1", vpar_q[0]); end
    end
    checks++; if (par_err_o !== 1'b1) begin failures++; $display("FAIL parity_hold got=%b exp=1", par_err_o); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_w[$];
    int          exp_t[$];
    logic [31:0] w;
    int t;
    clear_q();
    for (int k = 0; k < 6; k++) begin
      w = $urandom;
      send_bits(w, 32, 1, 20, 1, 20, t);
      exp_w.push_back(w);
      exp_t.push_back(t + PIPE);
      put(1'b0, 1'b0, int'($urandom_range(40, 2)));
    end
    put(1'b0, 1'b0, 10);
    checks++; if (vdat_q.size() != exp_w.size()) begin failures++; $display("FAIL b2b_count got=%0d exp=%0d", vdat_q.size(), exp_w.size()); end
    for (int k = 0; k < exp_w.size(); k++) begin
      if (k < vdat_q.size()) begin
        checks++; if (vdat_q[k] !== exp_w[k]) begin failures++; $display("FAIL b2b_dat[%0d] got=%h exp=%h", k, vdat_q[k], exp_w[k]); end
        checks++; if (vpar_q[k] !== exp_par_err(exp_w[k])) begin failures++; $display("FAIL b2b_par[%0d] got=%b exp=%b", k, vpar_q[k], exp_par_err(exp_w[k])); end
        checks++; if (vcyc_q[k] != exp_t[k]) begin failures++; $display("FAIL b2b_latency[%0d] got=%0d exp=%0d", k, vcyc_q[k], exp_t[k]); end
      end
    end
    checks++; if (ecyc_q.size() != 0) begin failures++; $display("FAIL b2b_err got=%0d exp=0", ecyc_q.size()); end
  endtask

  task automatic test_short_word();
    int t;
    clear_q();
    send_bits($urandom, 20, 1, 20, 1, 20, t);
    put(1'b0, 1'b0, 2*BT + 10);
    checks++;
    if (ecyc_q.size() != 1) begin
      failures++; $display("FAIL short_err_count got=%0d exp=1", ecyc_q.size());
    end else begin
      checks++; if (ecyc_q[0] != t + PIPE + 2*BT) begin failures++; $display("FAIL short_err_time got=%0d exp=%0d", ecyc_q[0], t + PIPE + 2*BT); end
    end
    checks++; if (vdat_q.size() != 0) begin failures++; $display("FAIL short_vld got=%0d exp=0", vdat_q.size()); end
    clear_q();
    send_bits(32'h8000_0000, 32, 1, 20, 1, 20, t);
    put(1'b0, 1'b0, 10);
    checks++;
    if (vdat_q.size() != 1) begin
      failures++; $display("FAIL after_short_vld_count got=%0d exp=1", vdat_q.size());
    end else begin
      checks++; if (vdat_q[0] !== 32'h8000_0000) begin failures++; $display("FAIL after_short_dat got=%h exp=80000000", vdat_q[0]); end
      checks++; if (vpar_q[0] !== 1'b0) begin failures++; $display("FAIL after_short_par got=%b exp=0", vpar_q[0]); end
    end
  endtask

  task automatic test_illegal();
    logic [31:0] w;
    int t;
    clear_q();
    w = $urandom;
    send_bits(w, 5, 1, 20, 1, 20, t);
    put(1'b0, 1'b0, int'($urandom_range(20, 1)));
    put(w[5], ~w[5], int'($urandom_range(20, 1)));
    t = cyc;
    put(1'b1, 1'b1, 5);
    put(1'b0, 1'b0, 2*BT + 10);
    checks++;
    if (ecyc_q.size() != 1) begin
      failures++; $display("FAIL illegal_err_count got=%0d exp=1", ecyc_q.size());
    end else begin
      checks++; if (ecyc_q[0] != t + PIPE) begin failures++; $display("FAIL illegal_err_time got=%0d exp=%0d", ecyc_q[0], t + PIPE); end
    end
    checks++; if (vdat_q.size() != 0) begin failures++; $display("FAIL illegal_vld got=%0d exp=0", vdat_q.size()); end
    clear_q();
    w = $urandom;
    send_bits(w, 32, 1, 20, 1, 20, t);
    put(1'b0, 1'b0, 10);
    checks++;
    if (vdat_q.size() != 1) begin
      failures++; $display("FAIL after_illegal_vld_count got=%0d exp=1", vdat_q.size());
    end else begin
      checks++; if (vdat_q[0] !== w) begin failures++; $display("FAIL after_illegal_dat got=%h exp=%h", vdat_q[0], w); end
    end
  endtask

  task automatic test_speed(output logic [31:0] last_w);
    logic [31:0] w;
    int t;
    clear_q();
    w = $urandom;
    send_bits(w, 12, 1, 20, 1, 20, t);
    put(1'b0, 1'b0, 2);
    spd_i = 1'b0;
    put(w[12], ~w[12], 5);
    put(1'b0, 1'b0, 3);
    spd_i = 1'b1;
    send_bits(w >> 13, 19, 1, 20, 1, 20, t);
    put(1'b0, 1'b0, 2*BT + 10);
    checks++; if (vdat_q.size() != 0) begin failures++; $display("FAIL speed_vld got=%0d exp=0", vdat_q.size()); end
    checks++; if (ecyc_q.size() != 0) begin failures++; $display("FAIL speed_err got=%0d exp=0", ecyc_q.size()); end
    clear_q();
    w = $urandom | 32'h0000_0100;
    send_bits(w, 32, 1, 20, 1, 20, t);
    put(1'b0, 1'b0, 10);
    last_w = w;
    checks++;
    if (vdat_q.size() != 1) begin
      failures++; $display("FAIL after_speed_vld_count got=%0d exp=1", vdat_q.size());
    end else begin
      checks++; if (vdat_q[0] !== w) begin failures++; $display("FAIL after_speed_dat got=%h exp=%h", vdat_q[0], w); end
      checks++; if (vpar_q[0] !== exp_par_err(w)) begin failures++; $display("FAIL after_speed_par got=%b exp=%b", vpar_q[0], exp_par_err(w)); end
    end
  endtask

  task automatic test_reset_midword(input logic [31:0] last_w);
    logic [31:0] w;
    int t;
    checks++; if (dat_o !== last_w) begin failures++; $display("FAIL pre_reset_hold got=%h exp=%h", dat_o, last_w); end
    clear_q();
    w = $urandom;
    send_bits(w, 16, 1, 20, 1, 20, t);
    put(1'b0, 1'b0, 3);
    put(w[16], ~w[16], 3);
    rst_i = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (dat_o !== 32'h0) begin failures++; $display("FAIL midreset_dat got=%h exp=0", dat_o); end
    checks++; if (vld_o !== 1'b0) begin failures++; $display("FAIL midreset_vld got=%b exp=0", vld_o); end
    put(1'b0, 1'b0, 2);
    rst_i = 1'b1;
    put(1'b0, 1'b0, 2*BT + 10);
    checks++; if (vdat_q.size() != 0) begin failures++; $display("FAIL midreset_stray_vld got=%0d exp=0", vdat_q.size()); end
    clear_q();
    w = $urandom;
    send_bits(w, 32, 1, 20, 1, 20, t);
    put(1'b0, 1'b0, 10);
    checks++;
    if (vdat_q.size() != 1) begin
      failures++; $display("FAIL after_reset_vld_count got=%0d exp=1", vdat_q.size());
    end else begin
      checks++; if (vdat_q[0] !== w) begin failures++; $display("FAIL after_reset_dat got=%h exp=%h", vdat_q[0], w); end
      checks++; if (vcyc_q[0] != t + PIPE) begin failures++; $display("FAIL after_reset_latency got=%0d exp=%0d", vcyc_q[0], t + PIPE); end
    end
  endtask

  initial begin
    logic [31:0] last_w;
    test_reset();
    test_powerup();
    test_basic();
    test_parity();
    test_back_to_back();
    test_short_word();
    test_illegal();
    test_speed(last_w);
    test_reset_midword(last_w);
    checks++; if (both_cnt != 0) begin failures++; $display("FAIL vld_err_overlap got=%0d exp=0", both_cnt); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
